// File: rtl/coeff_bank_fir_nport.sv
// Double-buffered FIR coefficient store with NumRd registered read ports and
// optional symmetric address folding; the host fills the shadow bank, then swaps.
module coeff_bank_fir_nport #(
    parameter int DataWidth = 16,
    parameter int Taps      = 38,
    parameter int NumRd     = 2,
    parameter int Symmetric = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          ren_i,
    input  logic [NumRd*$clog2(Taps)-1:0] addr_i,
    output logic [NumRd*DataWidth-1:0]    data_o,
    input  logic                          wvalid_i,
    output logic                          wready_o,
    input  logic [$clog2(Taps)-1:0]       waddr_i,
    input  logic [DataWidth-1:0]          wdata_i,
    input  logic                          swap_req_i,
    output logic                          swap_done_o,
    output logic                          bank_sel_o,
    output logic                          loaded_o,
    output logic                          err_o
);

    localparam int Depth = (Symmetric != 0) ? (Taps + 1) / 2 : Taps;
    localparam int AW    = $clog2(Taps);
    localparam int IW    = (Depth > 1) ? $clog2(Depth) : 1;

    // One extra bit so a power-of-two Taps still compares correctly.
    localparam logic [AW:0] DepthW = (AW + 1)'(Depth);
    localparam logic [AW:0] TapsW  = (AW + 1)'(Taps);
    localparam logic [AW:0] LastW  = (AW + 1)'(Taps - 1);

    typedef enum logic {
        IDLE,
        PEND
    } state_e;

    state_e                       state_q, state_d;
    logic                         bank_sel_q, bank_sel_d;
    logic                         swap_done_q, swap_done_d;
    logic                         err_q, err_d;
    logic [Depth-1:0]             written_q, written_d;
    logic [NumRd*DataWidth-1:0]   data_q, data_d;
    logic [DataWidth-1:0]         bank0_q [Depth];
    logic [DataWidth-1:0]         bank1_q [Depth];

    logic                         do_swap;
    logic                         wr_fire;
    logic                         wr_inrange;
    logic                         wr_en;
    logic [IW-1:0]                wr_idx;
    logic [NumRd-1:0]             rd_oob;
    logic [NumRd*DataWidth-1:0]   rd_word;

    assign wready_o    = (state_q == IDLE);
    assign wr_fire     = wvalid_i & wready_o;
    assign wr_inrange  = ({1'b0, waddr_i} < DepthW);
    assign wr_en       = wr_fire & wr_inrange;
    assign wr_idx      = IW'(waddr_i);

    // Addresses past Depth mirror onto Taps-1-addr; with Symmetric=0 they are all out of range.
    for (genvar k = 0; k < NumRd; k++) begin : g_rd
        logic [AW:0]   addr_ext;
        logic [AW:0]   fold;
        logic [IW-1:0] idx;

        assign addr_ext  = {1'b0, addr_i[k*AW +: AW]};
        assign fold      = (addr_ext < DepthW) ? addr_ext : (LastW - addr_ext);
        assign idx       = IW'(fold);
        assign rd_oob[k] = (addr_ext >= TapsW);
        assign rd_word[k*DataWidth +: DataWidth] = bank_sel_q ? bank1_q[idx] : bank0_q[idx];
    end

    always_comb begin
        state_d = state_q;
        do_swap = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (swap_req_i) begin
                    if (!ren_i) begin
                        do_swap = 1'b1;
                    end else begin
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                if (!ren_i) begin
                    do_swap = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bank_sel_d  = bank_sel_q ^ do_swap;
        swap_done_d = do_swap;
        err_d       = err_q | wr_fire & ~wr_inrange | ren_i & (|rd_oob);
        written_d   = written_q;
        if (wr_en) begin
            written_d[wr_idx] = 1'b1;
        end
        // A write landing on the swap edge is already in the new active bank.
        if (do_swap) begin
            written_d = '0;
        end
        data_d = data_q;
        if (ren_i) begin
            for (int k = 0; k < NumRd; k++) begin
                data_d[k*DataWidth +: DataWidth] =
                    rd_oob[k] ? '0 : rd_word[k*DataWidth +: DataWidth];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            bank_sel_q  <= 1'b0;
            swap_done_q <= 1'b0;
            err_q       <= 1'b0;
            written_q   <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            bank_sel_q  <= bank_sel_d;
            swap_done_q <= swap_done_d;
            err_q       <= err_d;
            written_q   <= written_d;
            data_q      <= data_d;
        end
    end

    // Writes always target the bank that is not currently selected for reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                bank0_q[i] <= '0;
                bank1_q[i] <= '0;
            end
        end else if (wr_en) begin
            if (bank_sel_q) begin
                bank0_q[wr_idx] <= wdata_i;
            end else begin
                bank1_q[wr_idx] <= wdata_i;
            end
        end
    end

    assign data_o      = data_q;
    assign swap_done_o = swap_done_q;
    assign bank_sel_o  = bank_sel_q;
    assign loaded_o    = &written_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_coeff_bank_fir_nport.sv
// Directed-vector bench for coeff_bank_fir_nport (Taps=38, symmetric, two read ports).
module tb_coeff_bank_fir_nport;

    logic        clk;
    logic        rstN;
    logic        ren;
    logic [11:0] addr;
    logic [31:0] dataOut;
    logic        wvalid;
    logic        wready;
    logic [5:0]  waddr;
    logic [15:0] wdata;
    logic        swapReq;
    logic        swapDone;
    logic        bankSel;
    logic        loaded;
    logic        err;

    int checks;
    int failures;

    coeff_bank_fir_nport #(
        .DataWidth(16),
        .Taps(38),
        .NumRd(2),
        .Symmetric(1)
    ) dut (
        .clk_i(clk),
        .rst_ni(rstN),
        .ren_i(ren),
        .addr_i(addr),
        .data_o(dataOut),
        .wvalid_i(wvalid),
        .wready_o(wready),
        .waddr_i(waddr),
        .wdata_i(wdata),
        .swap_req_i(swapReq),
        .swap_done_o(swapDone),
        .bank_sel_o(bankSel),
        .loaded_o(loaded),
        .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] coefOf(input int i);
        case (i)
            0:       coefOf = 16'h017b;
            1:       coefOf = 16'h0016;
            18:      coefOf = 16'h7fff;
            default: coefOf = 16'h0100 + 16'(i * 17);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeWord(input logic [5:0] a, input logic [15:0] d);
        wvalid = 1'b1;
        waddr  = a;
        wdata  = d;
        tick();
        wvalid = 1'b0;
    endtask

    task automatic readPair(input logic [5:0] a0, input logic [5:0] a1);
        ren  = 1'b1;
        addr = {a1, a0};
        tick();
        ren  = 1'b0;
    endtask

    task automatic doSwap();
        swapReq = 1'b1;
        ren     = 1'b0;
        tick();
        swapReq = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (2) tick();
        checks++; if (dataOut !== 32'h0) begin failures++; $display("[TB] FAIL reset_data got=%h exp=%h", dataOut, 32'h0); end
        checks++; if (bankSel !== 1'b0) begin failures++; $display("[TB] FAIL reset_bank_sel got=%b exp=0", bankSel); end
        checks++; if (wready !== 1'b1) begin failures++; $display("[TB] FAIL reset_wready got=%b exp=1", wready); end
        checks++; if (loaded !== 1'b0) begin failures++; $display("[TB] FAIL reset_loaded got=%b exp=0", loaded); end
        checks++; if (swapDone !== 1'b0) begin failures++; $display("[TB] FAIL reset_swap_done got=%b exp=0", swapDone); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", err); end
        rstN = 1'b1;
        tick();
        readPair(6'd0, 6'd37);
        checks++; if (dataOut !== 32'h0) begin failures++; $display("[TB] FAIL reset_read got=%h exp=%h", dataOut, 32'h0); end
    endtask

    task automatic test_load_swap();
        for (int i = 0; i < 18; i++) writeWord(6'(i), coefOf(i));
        checks++; if (loaded !== 1'b0) begin failures++; $display("[TB] FAIL partial_loaded got=%b exp=0", loaded); end
        writeWord(6'd18, coefOf(18));
        checks++; if (loaded !== 1'b1) begin failures++; $display("[TB] FAIL full_loaded got=%b exp=1", loaded); end
        checks++; if (bankSel !== 1'b0) begin failures++; $display("[TB] FAIL load_bank_sel got=%b exp=0", bankSel); end
        doSwap();
        checks++; if (bankSel !== 1'b1) begin failures++; $display("[TB] FAIL swap_bank_sel got=%b exp=1", bankSel); end
        checks++; if (swapDone !== 1'b1) begin failures++; $display("[TB] FAIL swap_done_pulse got=%b exp=1", swapDone); end
        checks++; if (loaded !== 1'b0) begin failures++; $display("[TB] FAIL swap_loaded_clear got=%b exp=0", loaded); end
        tick();
        checks++; if (swapDone !== 1'b0) begin failures++; $display("[TB] FAIL swap_done_width got=%b exp=0", swapDone); end
        readPair(6'd0, 6'd37);
        checks++; if (dataOut !== 32'h017b017b) begin failures++; $display("[TB] FAIL fold_0_37 got=%h exp=%h", dataOut, 32'h017b017b); end
        readPair(6'd18, 6'd19);
        checks++; if (dataOut !== 32'h7fff7fff) begin failures++; $display("[TB] FAIL fold_18_19 got=%h exp=%h", dataOut, 32'h7fff7fff); end
        readPair(6'd1, 6'd36);
        checks++; if (dataOut !== 32'h00160016) begin failures++; $display("[TB] FAIL fold_1_36 got=%h exp=%h", dataOut, 32'h00160016); end
    endtask

    task automatic test_write_no_swap();
        logic [15:0] c5;
        c5 = coefOf(5);
        writeWord(6'd5, 16'h1234);
        readPair(6'd5, 6'd32);
        checks++; if (dataOut !== {c5, c5}) begin failures++; $display("[TB] FAIL shadow_isolated got=%h exp=%h", dataOut, {c5, c5}); end
        doSwap();
        checks++; if (bankSel !== 1'b0) begin failures++; $display("[TB] FAIL second_swap_sel got=%b exp=0", bankSel); end
        readPair(6'd5, 6'd32);
        checks++; if (dataOut !== 32'h12341234) begin failures++; $display("[TB] FAIL new_coef_5_32 got=%h exp=%h", dataOut, 32'h12341234); end
        readPair(6'd0, 6'd37);
        checks++; if (dataOut !== 32'h0) begin failures++; $display("[TB] FAIL unwritten_kept got=%h exp=%h", dataOut, 32'h0); end
    endtask

    task automatic test_pending_swap();
        logic [15:0] c5;
        c5 = coefOf(5);
        swapReq = 1'b1;
        ren     = 1'b1;
        addr    = {6'd32, 6'd5};
        for (int c = 0; c < 5; c++) begin
            tick();
            swapReq = 1'b0;
            checks++; if (wready !== 1'b0) begin failures++; $display("[TB] FAIL pend_wready cyc=%0d got=%b exp=0", c, wready); end
            checks++; if (bankSel !== 1'b0) begin failures++; $display("[TB] FAIL pend_bank_sel cyc=%0d got=%b exp=0", c, bankSel); end
            checks++; if (dataOut !== 32'h12341234) begin failures++; $display("[TB] FAIL pend_old_data cyc=%0d got=%h exp=%h", c, dataOut, 32'h12341234); end
        end
        ren = 1'b0;
        tick();
        checks++; if (bankSel !== 1'b1) begin failures++; $display("[TB] FAIL pend_swap_sel got=%b exp=1", bankSel); end
        checks++; if (swapDone !== 1'b1) begin failures++; $display("[TB] FAIL pend_swap_done got=%b exp=1", swapDone); end
        checks++; if (wready !== 1'b1) begin failures++; $display("[TB] FAIL pend_exit_wready got=%b exp=1", wready); end
        readPair(6'd5, 6'd32);
        checks++; if (dataOut !== {c5, c5}) begin failures++; $display("[TB] FAIL former_active_intact got=%h exp=%h", dataOut, {c5, c5}); end
    endtask

    task automatic test_simultaneous();
        wvalid  = 1'b1;
        waddr   = 6'd3;
        wdata   = 16'hbeef;
        swapReq = 1'b1;
        ren     = 1'b0;
        tick();
        wvalid  = 1'b0;
        swapReq = 1'b0;
        checks++; if (bankSel !== 1'b0) begin failures++; $display("[TB] FAIL simul_bank_sel got=%b exp=0", bankSel); end
        checks++; if (swapDone !== 1'b1) begin failures++; $display("[TB] FAIL simul_swap_done got=%b exp=1", swapDone); end
        checks++; if (loaded !== 1'b0) begin failures++; $display("[TB] FAIL simul_loaded got=%b exp=0", loaded); end
        readPair(6'd3, 6'd34);
        checks++; if (dataOut !== 32'hbeefbeef) begin failures++; $display("[TB] FAIL simul_write_first got=%h exp=%h", dataOut, 32'hbeefbeef); end
        readPair(6'd5, 6'd0);
        checks++; if (dataOut !== 32'h00001234) begin failures++; $display("[TB] FAIL simul_ports_indep got=%h exp=%h", dataOut, 32'h00001234); end
    endtask

    task automatic test_write_err();
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL err_before_bad_write got=%b exp=0", err); end
        writeWord(6'd19, 16'hffff);
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL bad_write_err got=%b exp=1", err); end
        checks++; if (wready !== 1'b1) begin failures++; $display("[TB] FAIL bad_write_wready got=%b exp=1", wready); end
        readPair(6'd18, 6'd3);
        checks++; if (dataOut !== 32'hbeef0000) begin failures++; $display("[TB] FAIL bad_write_no_change got=%h exp=%h", dataOut, 32'hbeef0000); end
    endtask

    task automatic test_reset_pend();
        swapReq = 1'b1;
        ren     = 1'b1;
        addr    = {6'd34, 6'd3};
        tick();
        swapReq = 1'b0;
        checks++; if (wready !== 1'b0) begin failures++; $display("[TB] FAIL pre_reset_pend got=%b exp=0", wready); end
        checks++; if (dataOut !== 32'hbeefbeef) begin failures++; $display("[TB] FAIL pre_reset_data got=%h exp=%h", dataOut, 32'hbeefbeef); end
        #2;
        rstN = 1'b0;
        #1;
        checks++; if (dataOut !== 32'h0) begin failures++; $display("[TB] FAIL async_rst_data got=%h exp=%h", dataOut, 32'h0); end
        checks++; if (wready !== 1'b1) begin failures++; $display("[TB] FAIL async_rst_wready got=%b exp=1", wready); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL async_rst_err got=%b exp=0", err); end
        checks++; if (bankSel !== 1'b0 || swapDone !== 1'b0 || loaded !== 1'b0) begin
            failures++; $display("[TB] FAIL async_rst_flags got=%b%b%b exp=000", bankSel, swapDone, loaded);
        end
        ren = 1'b0;
        #2;
        rstN = 1'b1;
        tick();
        readPair(6'd3, 6'd34);
        checks++; if (dataOut !== 32'h0) begin failures++; $display("[TB] FAIL post_rst_read got=%h exp=%h", dataOut, 32'h0); end
        doSwap();
        readPair(6'd3, 6'd5);
        checks++; if (dataOut !== 32'h0) begin failures++; $display("[TB] FAIL post_rst_shadow_zero got=%h exp=%h", dataOut, 32'h0); end
    endtask

    task automatic test_read_err();
        writeWord(6'd0, 16'h5a5a);
        doSwap();
        checks++; if (bankSel !== 1'b0) begin failures++; $display("[TB] FAIL rderr_bank_sel got=%b exp=0", bankSel); end
        readPair(6'd0, 6'd37);
        checks++; if (dataOut !== 32'h5a5a5a5a) begin failures++; $display("[TB] FAIL rderr_prefill got=%h exp=%h", dataOut, 32'h5a5a5a5a); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL rderr_before got=%b exp=0", err); end
        readPair(6'd38, 6'd0);
        checks++; if (dataOut !== 32'h5a5a0000) begin failures++; $display("[TB] FAIL oob_read_zero got=%h exp=%h", dataOut, 32'h5a5a0000); end
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL oob_read_err got=%b exp=1", err); end
        ren  = 1'b0;
        addr = {6'd1, 6'd1};
        repeat (3) tick();
        checks++; if (dataOut !== 32'h5a5a0000) begin failures++; $display("[TB] FAIL ren_low_hold got=%h exp=%h", dataOut, 32'h5a5a0000); end
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL err_sticky got=%b exp=1", err); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstN     = 1'b0;
        ren      = 1'b0;
        addr     = '0;
        wvalid   = 1'b0;
        waddr    = '0;
        wdata    = '0;
        swapReq  = 1'b0;
        test_reset();
        test_load_swap();
        test_write_no_swap();
        test_pending_swap();
        test_simultaneous();
        test_write_err();
        test_reset_pend();
        test_read_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coeff_bank_fir_nport.md
Name: coeff_bank_fir_nport

Overview:
Double-buffered, runtime-reloadable coefficient store for FIR filters with a parametrised number of read ports (NumRd multiplications/cycle).
- Optional symmetric folding: stores only ceil(Taps/2) words and mirrors upper addresses.
- A host loads the shadow bank through a valid/ready write port, then requests a bank swap; the swap is applied only when no read is issued, so the filter datapath never sees a mixed coefficient set.
- Sits between the configuration interface and the FIR MAC datapath.

Parameters:
DataWidth, 16, coefficient width (two's complement)
Taps, 38, number of filter taps
NumRd, 2, number of parallel read ports
Symmetric, 1, 1 = store ceil(Taps/2) words and fold addresses; 0 = store Taps words

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ren_i  in  1  read enable for all ports
addr_i  in  NumRd*$clog2(Taps)  packed read addresses, port k at [k*AW +: AW]
data_o  out  NumRd*DataWidth  packed registered read data, port k at [k*DataWidth +: DataWidth]
wvalid_i  in  1  shadow write valid
wready_o  out  1  shadow write ready
waddr_i  in  $clog2(Taps)  shadow write address (stored index)
wdata_i  in  DataWidth  shadow write data
swap_req_i  in  1  request active/shadow swap (single-cycle pulse)
swap_done_o  out  1  one-cycle pulse when the swap is applied
bank_sel_o  out  1  index of the active bank
loaded_o  out  1  every stored shadow entry written since last swap
err_o  out  1  sticky: out-of-range read or write address seen

Behaviour:
- Storage: two banks of Depth words each. Depth = Symmetric ? (Taps+1)/2 : Taps. AW = $clog2(Taps).
- Reset values: all bank words 0, data_o 0, bank_sel_o 0, wready_o 1, swap_done_o 0, loaded_o 0, err_o 0, state IDLE.
- Read address fold (Symmetric=1):
  - addr < Depth → idx = addr
  - Depth ≤ addr < Taps → idx = Taps-1-addr
  - addr ≥ Taps → value 0 and err_o set
  - Symmetric=0: idx = addr; addr ≥ Taps → 0 and err_o set.
- Read latency: exactly 1 cycle. When ren_i=1 at edge N, data_o port k = active_bank[idx_k] after edge N. When ren_i=0, data_o holds its last value. Ports are independent; equal addresses are legal.
- Write handshake: a write is accepted on an edge with wvalid_i & wready_o. It writes shadow_bank[waddr_i] = wdata_i and sets the written bit for waddr_i.
  - waddr_i ≥ Depth: write dropped, err_o set, handshake still completes.
  - wready_o = 0 in state PEND.
  - Writes never touch the active bank.
- loaded_o = AND of the Depth written bits. Written bits clear on swap.
- State machine:
  - IDLE: wready_o=1. A swap_req_i goes to PEND, or swaps immediately per the PEND rule if ren_i=0 in the same cycle.
  - PEND: wready_o=0. On the first edge with ren_i=0: bank_sel_o toggles, written bits clear, swap_done_o pulses the next cycle, return to IDLE.
  - swap_req_i in PEND is ignored.
  - swap_req_i while loaded_o=0 is still honoured; unwritten entries keep their old shadow contents.
- Simultaneous events:
  - wvalid_i & swap_req_i in IDLE on the same edge: the write is accepted first into the old shadow bank, then the swap proceeds.
  - ren_i=1 on the swap edge: the read uses the old active bank.
- After a swap, the former active bank becomes the shadow bank with its contents intact.
- err_o clears only on reset.
- Reset mid-operation (PEND, pending write): everything returns to reset values immediately (asynchronous); bank contents are zeroed.
- Target: 120–400 lines RTL. No combinational path from inputs to data_o.

Test Plan:
- Reset → data_o=0, bank_sel_o=0, wready_o=1, loaded_o=0. Reads of addr 0/37 with ren_i=1 → 0,0 one cycle later.
- Write stored idx 0..18 with 16'h017b,16'h0016,…,16'h7fff; swap_req_i with ren_i=0 → swap_done_o pulse, bank_sel_o=1. Read addr1=0, addr2=37 → both 16'h017b. Read addr1=18, addr2=19 → both 16'h7fff.
- Hold ren_i=1 for 5 cycles after swap_req_i → wready_o=0 and bank_sel_o unchanged for 5 cycles. Swap occurs on the first ren_i=0 edge; all reads before it return old-bank values.
- Read addr=38 (Taps=38) → data 0 and err_o=1 sticky. Write waddr=19 → dropped, err_o=1, no bank change.
- Write idx 5 = 16'h1234 with no swap → reads of addr 5 unchanged. After swap → addr 5 and addr 32 read 16'h1234.
- Assert rst_ni low while in PEND → all outputs return to reset values immediately. Post-reset reads return 0.
